// File: rtl/demux8_buf_if.sv
// Handshake and bus bundle for demux8_buf: one producer stream in, eight buffered channels out.
// The master modport is the producer/consumer side; the slave modport is the demux itself.
interface demux8_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [2:0]           in_sel;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [8*WIDTH-1:0]   out_data;
    logic [CNT_W-1:0]     acc_count;

    modport master (
        output flush, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, acc_count
    );

    modport slave (
        input  flush, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, acc_count
    );
endinterface

// File: rtl/demux8_buf.sv
// Routes a word stream into one of eight 1-entry holding registers selected per word,
// with per-channel valid/ready drain, a synchronous flush and a wrapping accept counter.
module demux8_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    demux8_buf_if.slave    bus
);

    logic [7:0]        valid_r;
    logic [7:0]        valid_nxt_s;
    logic [WIDTH-1:0]  data_r [8];
    logic [CNT_W-1:0]  count_r;
    logic              ready_s;
    logic              accept_s;

    // Ready passes the target channel's out_ready through so a full channel can drain and reload in one edge.
    always_comb begin
        ready_s  = ~bus.flush & (~valid_r[bus.in_sel] | bus.out_ready[bus.in_sel]);
        accept_s = bus.in_valid & ready_s;
    end

    // Per-channel valid next state: flush beats load, load beats drain.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < 8; i++) begin
            if (bus.flush) begin
                valid_nxt_s[i] = 1'b0;
            end else if (accept_s && (bus.in_sel == 3'(i))) begin
                valid_nxt_s[i] = 1'b1;
            end else if (bus.out_ready[i]) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
            end
        end
    end

    // Channel valid flags and accept counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 8'h00;
            count_r <= {CNT_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            if (accept_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Channel data registers only change on a load, so stale data stays visible while invalid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            data_r[bus.in_sel] <= bus.in_data;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_r;
    assign bus.acc_count = count_r;

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign bus.out_data[g*WIDTH +: WIDTH] = data_r[g];
    end

endmodule

// File: tb/tb_demux8_buf.sv
// Self-checking bench for demux8_buf: a per-cycle reference model plus directed literal checks,
// and a second narrow-counter instance for the wrap and mid-stream reset cases.
module tb_demux8_buf;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic check_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    demux8_buf_if #(.WIDTH(W), .CNT_W(16)) if1 ();
    demux8_buf_if #(.WIDTH(W), .CNT_W(4))  if2 ();

    demux8_buf #(.WIDTH(W), .CNT_W(16)) dut1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));
    demux8_buf #(.WIDTH(W), .CNT_W(4))  dut2 (.clock(clock), .reset_n(reset_n), .bus(if2.slave));

    // Reference model: channel contents as plain arrays, updated from the handshake rules.
    logic [7:0]      exp_valid;
    logic [W-1:0]    exp_data [8];
    logic [15:0]     exp_count;
    logic            exp_rdy;
    logic [8*W-1:0]  exp_flat;

    assign exp_rdy = !if1.flush && (!exp_valid[if1.in_sel] || if1.out_ready[if1.in_sel]);

    always_comb begin
        exp_flat = '0;
        for (int i = 0; i < 8; i++) exp_flat[i*W +: W] = exp_data[i];
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_valid <= 8'h00;
            for (int i = 0; i < 8; i++) exp_data[i] <= '0;
            exp_count <= 16'd0;
        end else if (if1.flush) begin
            exp_valid <= 8'h00;
        end else begin
            exp_valid <= exp_valid & ~if1.out_ready;
            if (if1.in_valid && exp_rdy) begin
                exp_valid[if1.in_sel] <= 1'b1;
                exp_data[if1.in_sel]  <= if1.in_data;
                exp_count             <= exp_count + 16'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        if (check_en) begin
            chk("in_ready",  {255'd0, if1.in_ready}, {255'd0, exp_rdy});
            chk("out_valid", {248'd0, if1.out_valid}, {248'd0, exp_valid});
            chk("out_data",  if1.out_data, exp_flat);
            chk("acc_count", {240'd0, if1.acc_count}, {240'd0, exp_count});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d, input logic [7:0] r);
        if1.in_valid  = v;
        if1.in_sel    = s;
        if1.in_data   = d;
        if1.out_ready = r;
    endtask

    initial begin
        // Reset with arbitrary inputs present.
        if1.flush = 1'b0;
        drive(1'b1, 3'd3, $urandom, 8'hFF);
        if2.flush = 1'b0; if2.in_valid = 1'b0; if2.in_sel = 3'd0; if2.in_data = '0; if2.out_ready = 8'h00;
        #12;
        chk("rst_valid", {248'd0, if1.out_valid}, 256'd0);
        chk("rst_data",  if1.out_data, 256'd0);
        chk("rst_count", {240'd0, if1.acc_count}, 256'd0);
        drive(1'b0, 3'd0, '0, 8'h00);
        @(posedge clock); #1;
        reset_n = 1'b1;
        check_en = 1'b1;

        // Route one word to channel 5.
        drive(1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
        #1 chk("route_rdy", {255'd0, if1.in_ready}, {255'd0, 1'b1});
        tick();
        if1.in_valid = 1'b0;
        chk("route_valid", {248'd0, if1.out_valid}, {248'd0, 8'h20});
        chk("route_ch5",   {224'd0, if1.out_data[5*W +: W]}, {224'd0, 32'hDEADBEEF});
        chk("route_cnt",   {240'd0, if1.acc_count}, {240'd0, 16'd1});

        // Backpressure, then drain and reload on the same edge.
        drive(1'b1, 3'd5, 32'h12345678, 8'h00);
        #1 chk("bp_rdy", {255'd0, if1.in_ready}, 256'd0);
        tick();
        chk("bp_ch5", {224'd0, if1.out_data[5*W +: W]}, {224'd0, 32'hDEADBEEF});
        chk("bp_cnt", {240'd0, if1.acc_count}, {240'd0, 16'd1});
        if1.out_ready = 8'h20;
        #1 chk("pass_rdy", {255'd0, if1.in_ready}, {255'd0, 1'b1});
        tick();
        drive(1'b0, 3'd0, '0, 8'h00);
        chk("reload_valid", {248'd0, if1.out_valid}, {248'd0, 8'h20});
        chk("reload_ch5",   {224'd0, if1.out_data[5*W +: W]}, {224'd0, 32'h12345678});
        chk("reload_cnt",   {240'd0, if1.acc_count}, {240'd0, 16'd2});

        // Parallel drains alongside a load.
        if1.out_ready = 8'hFF;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'h100 + 32'(i), 8'h00);
            tick();
        end
        chk("fill_valid", {248'd0, if1.out_valid}, {248'd0, 8'hFF});
        drive(1'b1, 3'd3, 32'hAAAA, 8'hFF);
        tick();
        drive(1'b0, 3'd0, '0, 8'h00);
        chk("par_valid", {248'd0, if1.out_valid}, {248'd0, 8'h08});
        chk("par_ch3",   {224'd0, if1.out_data[3*W +: W]}, {224'd0, 32'hAAAA});
        chk("par_ch0",   {224'd0, if1.out_data[0*W +: W]}, {224'd0, 32'h100});
        chk("par_cnt",   {240'd0, if1.acc_count}, {240'd0, 16'd11});

        // Flush with a pending word: clears valids only.
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                drive(1'b1, 3'(i), 32'h200 + 32'(i), 8'h00);
                tick();
            end
        end
        drive(1'b1, 3'd2, 32'hBAD, 8'hFF);
        if1.flush = 1'b1;
        #1 chk("flush_rdy", {255'd0, if1.in_ready}, 256'd0);
        tick();
        if1.flush = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        chk("flush_valid", {248'd0, if1.out_valid}, 256'd0);
        chk("flush_ch2",   {224'd0, if1.out_data[2*W +: W]}, {224'd0, 32'h202});
        chk("flush_cnt",   {240'd0, if1.acc_count}, {240'd0, 16'd18});

        // Random traffic checked by the model.
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 8'($urandom));
            if1.flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        if1.flush = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);

        // Counter wrap on the 4-bit instance: 17 accepts leave 1.
        if2.out_ready = 8'hFF;
        if2.in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if2.in_sel  = 3'(i % 8);
            if2.in_data = 32'hC000 + 32'(i);
            tick();
        end
        chk("wrap_cnt", {252'd0, if2.acc_count}, {252'd0, 4'd1});

        // Asynchronous reset mid-stream clears everything before any edge.
        if2.out_ready = 8'h00;
        drive(1'b1, 3'd6, 32'h77, 8'h00);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid2", {248'd0, if2.out_valid}, 256'd0);
        chk("arst_data2",  if2.out_data, 256'd0);
        chk("arst_cnt2",   {252'd0, if2.acc_count}, 256'd0);
        chk("arst_valid1", {248'd0, if1.out_valid}, 256'd0);
        chk("arst_cnt1",   {240'd0, if1.acc_count}, 256'd0);
        if2.in_valid = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
